// File: rtl/mbr_pkg.sv
// mbr_pkg: shared types and default control-bit indices for the memory buffer register.
// Contents:
//   state_t    - transaction FSM states
//   LD_ACC_BIT - default control bit that loads the accumulator value
//   LD_MEM_BIT - default control bit that starts a memory read
//   ST_MEM_BIT - default control bit that starts a memory write
package mbr_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    localparam int LD_ACC_BIT = 10;
    localparam int LD_MEM_BIT = 5;
    localparam int ST_MEM_BIT = 9;
endpackage

// File: rtl/mbr_timeout_cnt.sv
// mbr_timeout_cnt: wait-cycle counter that flags the last permitted cycle of a transaction.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - return the count to zero
//   en         - count this cycle (a wait cycle without acknowledge)
//   expire     - this enabled cycle is the TIMEOUT-th wait cycle
module mbr_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    // TIMEOUT=1 would give a zero-width counter, so keep at least one bit
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt;
    assign expire = en && (cnt == LAST);
    // holding at LAST means the count can never wrap inside a transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mbr_unit.sv
// mbr_unit: memory buffer register with accumulator load and timed memory read/write.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   control_signals - decoded control word; bits selected by LD_ACC_BIT/LD_MEM_BIT/ST_MEM_BIT
//   acc2mbr         - accumulator data for a direct load
//   mem_rdata       - memory read data, valid with mem_ack
//   mem_ack         - memory completion strobe
//   err_clr         - clears the sticky timeout flag
//   mem_req, mem_we - registered memory request and direction (1 = write)
//   mem_wdata       - write data, always the register contents
//   mbr_data        - register contents
//   busy            - a memory transaction is outstanding
//   timeout_err     - sticky flag set when a transaction is aborted for lack of ack
module mbr_unit
    import mbr_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CTRL_W     = 16,
    parameter int LD_ACC_BIT = mbr_pkg::LD_ACC_BIT,
    parameter int LD_MEM_BIT = mbr_pkg::LD_MEM_BIT,
    parameter int ST_MEM_BIT = mbr_pkg::ST_MEM_BIT,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] control_signals,
    input  logic [DATA_W-1:0] acc2mbr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              err_clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mbr_data,
    output logic              busy,
    output logic              timeout_err
);
    state_t            state, state_d;
    logic [DATA_W-1:0] data_d;
    logic              we_d, err_d, expire;
    logic              unused_ctrl;

    assign unused_ctrl = ^control_signals;
    assign busy        = state != IDLE;
    assign mem_wdata   = mbr_data;

    mbr_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!busy),
        .en     (busy && !mem_ack),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mbr_data    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            mbr_data    <= data_d;
            mem_req     <= state_d != IDLE;
            mem_we      <= we_d;
            timeout_err <= err_d;
        end
    end

    // a timeout overrides err_clr; an ack overrides a timeout
    always_comb begin
        state_d = state;
        data_d  = mbr_data;
        we_d    = mem_we;
        err_d   = timeout_err && !err_clr;
        case (state)
            IDLE: begin
                if (control_signals[LD_ACC_BIT]) begin
                    data_d = acc2mbr;
                end else if (control_signals[LD_MEM_BIT]) begin
                    state_d = RD_WAIT;
                    we_d    = 1'b0;
                end else if (control_signals[ST_MEM_BIT]) begin
                    state_d = WR_WAIT;
                    we_d    = 1'b1;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    data_d  = (state == RD_WAIT) ? mem_rdata : mbr_data;
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mbr_unit.sv
// tb_mbr_unit: scoreboard bench for mbr_unit against a transaction-level reference model.
module tb_mbr_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] ctrl = '0, acc = '0, rdata = '0;
    logic        ack = 1'b0, clr = 1'b0;
    logic        mem_req, mem_we, busy, timeout_err;
    logic [15:0] mem_wdata, mbr_data;

    mbr_unit #(.DATA_W(16), .CTRL_W(16), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .control_signals (ctrl),
        .acc2mbr         (acc),
        .mem_rdata       (rdata),
        .mem_ack         (ack),
        .err_clr         (clr),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mbr_data        (mbr_data),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        we;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;

    // reference model: a transaction either is or is not outstanding, and
    // carries its direction and the number of wait cycles spent so far
    logic        m_busy = 0, m_we = 0, m_err = 0;
    logic [15:0] m_data = '0;
    int          m_wait = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic [15:0] c, input logic [15:0] a, input logic [15:0] rd,
                       input logic k, input logic e);
        @(negedge clk);
        ctrl = c; acc = a; rdata = rd; ack = k; clr = e;
        if (!m_busy) begin
            if (c[10]) m_data = a;
            else if (c[5]) begin m_busy = 1; m_we = 0; m_wait = 0; end
            else if (c[9]) begin m_busy = 1; m_we = 1; m_wait = 0; end
            if (e) m_err = 0;
        end else begin
            m_wait++;
            if (k) begin
                if (!m_we) m_data = rd;
                m_busy = 0;
                if (e) m_err = 0;
            end else if (m_wait == TO) begin
                m_busy = 0;
                m_err  = 1;
            end else if (e) m_err = 0;
        end
        q.push_back('{m_busy, m_we, m_data, m_err});
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("busy", 32'(busy), 32'(x.busy));
                chk("mem_req", 32'(mem_req), 32'(x.busy));
                if (x.busy) chk("mem_we", 32'(mem_we), 32'(x.we));
                chk("mbr_data", 32'(mbr_data), 32'(x.data));
                chk("mem_wdata", 32'(mem_wdata), 32'(x.data));
                chk("timeout_err", 32'(timeout_err), 32'(x.err));
            end
        end
    end

    initial begin
        int r;
        logic [15:0] c;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_data", 32'(mbr_data), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_err", 32'(timeout_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cyc(16'h0400, 16'hA5A5, 16'h0, 0, 0);
        cyc(16'h0020, 16'h0, 16'h0, 0, 0);
        cyc(16'h0000, 16'h0, 16'h0, 0, 0);
        cyc(16'h0000, 16'h0, 16'h0, 0, 0);
        cyc(16'h0000, 16'h0, 16'h1234, 1, 0);
        cyc(16'h0400, 16'h00FF, 16'h0, 0, 0);
        cyc(16'h0200, 16'h0, 16'h0, 0, 0);
        cyc(16'h0000, 16'h0, 16'hDEAD, 1, 0);
        cyc(16'h0000, 16'h0, 16'hBEEF, 1, 0);
        cyc(16'h0020, 16'h0, 16'h0, 0, 0);
        repeat (TO) cyc(16'h0000, 16'h0, 16'h0, 0, 0);
        cyc(16'h0000, 16'h0, 16'h0, 0, 1);
        cyc(16'h0620, 16'hCAFE, 16'h0, 0, 0);
        cyc(16'h0020, 16'h0, 16'h0, 0, 0);
        repeat (TO - 1) cyc(16'h0400, 16'h1111, 16'h0, 0, 0);
        cyc(16'h0400, 16'h1111, 16'h7777, 1, 0);
        cyc(16'h0200, 16'h0, 16'h0, 0, 0);
        repeat (TO - 1) cyc(16'h0000, 16'h0, 16'h0, 0, 1);
        cyc(16'h0000, 16'h0, 16'h0, 0, 1);
        cyc(16'h0000, 16'h0, 16'h0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 5);
            c = (r == 0) ? 16'h0400 : (r == 1) ? 16'h0020 : (r == 2) ? 16'h0200 :
                (r == 3) ? 16'($urandom) : 16'h0000;
            cyc(c, 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0);
        end
        while (m_busy) cyc(16'h0000, 16'h0, 16'h0, 0, 0);

        cyc(16'h0400, 16'h5A5A, 16'h0, 0, 0);
        cyc(16'h0020, 16'h0, 16'h0, 0, 0);
        repeat (TO) cyc(16'h0000, 16'h0, 16'h0, 0, 0);
        cyc(16'h0200, 16'h0, 16'h0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_data", 32'(mbr_data), 0);
        chk("arst_err", 32'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_busy = 0; m_we = 0; m_err = 0; m_data = '0;
        cyc(16'h0000, 16'h0, 16'h0, 1, 0);
        cyc(16'h0400, 16'h3C3C, 16'h0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mbr_unit.md
MBR_UNIT -- requirements
Module: mbr_unit

Interface
REQ-001 Parameter DATA_W, default 16, width of the data register and all data ports.
REQ-002 Parameter CTRL_W, default 16, width of control_signals.
REQ-003 Parameter LD_ACC_BIT, default 10, control bit that loads acc2mbr.
REQ-004 Parameter LD_MEM_BIT, default 5, control bit that starts a memory read into the register.
REQ-005 Parameter ST_MEM_BIT, default 9, control bit that starts a memory write of the register.
REQ-006 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ack (legal range 1..255).
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 control_signals  input  CTRL_W  decoded control word from the control unit.
REQ-010 acc2mbr  input  DATA_W  data from the accumulator.
REQ-011 mem_rdata  input  DATA_W  read data from memory, valid when mem_ack=1.
REQ-012 mem_ack  input  1  memory completion strobe.
REQ-013 err_clr  input  1  clears timeout_err.
REQ-014 mem_req  output  1  memory request, registered.
REQ-015 mem_we  output  1  1 = write, 0 = read; meaningful while mem_req=1, registered.
REQ-016 mem_wdata  output  DATA_W  write data; equals mbr_data.
REQ-017 mbr_data  output  DATA_W  current register contents.
REQ-018 busy  output  1  high whenever a memory transaction is outstanding.
REQ-019 timeout_err  output  1  sticky flag, set when a transaction aborts.

Function
REQ-020 FSM states SHALL be IDLE, RD_WAIT and WR_WAIT; busy SHALL be 1 exactly when the state is not IDLE.
REQ-021 In IDLE, control bits SHALL be decoded with priority LD_ACC_BIT > LD_MEM_BIT > ST_MEM_BIT; lower-priority bits set in the same cycle are dropped.
REQ-022 In IDLE with LD_ACC_BIT=1: mbr_data <= acc2mbr at the edge; the state stays IDLE; there is no memory activity.
REQ-023 In IDLE with LD_MEM_BIT=1: at the edge, state <= RD_WAIT, mem_req <= 1, mem_we <= 0, and the wait counter is cleared.
REQ-024 In IDLE with ST_MEM_BIT=1: at the edge, state <= WR_WAIT, mem_req <= 1, mem_we <= 1, and the wait counter is cleared; mem_wdata is held stable for the whole transaction.
REQ-025 While busy, control_signals SHALL be ignored entirely, including LD_ACC_BIT, and mbr_data changes only by read completion.
REQ-026 In RD_WAIT, mem_ack=1 at an edge: mbr_data <= mem_rdata, mem_req <= 0, state <= IDLE.
REQ-027 In WR_WAIT, mem_ack=1 at an edge: mem_req <= 0, state <= IDLE, and mbr_data is unchanged.
REQ-028 Each wait cycle without ack SHALL increment the counter; if the counter equals TIMEOUT-1 and ack=0, the block SHALL set mem_req <= 0, state <= IDLE and timeout_err <= 1, leaving mbr_data unchanged; mem_req is therefore high for at most TIMEOUT cycles.
REQ-029 If ack arrives in the same cycle as timeout expiry, ack wins and timeout_err is not set.
REQ-030 mem_ack while IDLE SHALL be ignored.
REQ-031 err_clr=1 SHALL clear timeout_err at the edge; a timeout in the same cycle takes precedence and the flag stays 1.
REQ-032 A new command is accepted in the first IDLE cycle after completion, giving back-to-back throughput of one transaction per (1 + ack latency) cycles.
REQ-033 The counter width SHALL be $clog2(TIMEOUT) and its arithmetic SHALL never wrap within a transaction.

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE, mbr_data=0, mem_req=0, mem_we=0, counter=0, timeout_err=0, so busy=0 and mem_wdata=0.
REQ-035 Reset asserted mid-transaction SHALL drop mem_req immediately without waiting for a clock, and the aborted transaction is not flagged.

Structure
REQ-036 Package mbr_pkg SHALL hold the state enumeration and the default bit-index constants (LD_ACC_BIT, LD_MEM_BIT, ST_MEM_BIT).
REQ-037 The wait counter SHALL be one sub-module, mbr_timeout_cnt, with clear/enable inputs and an expire output, parameterised by TIMEOUT.

Verification
REQ-038 Apply reset, then set control bit 10 with acc2mbr=16'hA5A5 -> mbr_data=16'hA5A5 after 1 edge, while busy and mem_req stay 0.
REQ-039 Set bit 5 with ack after 3 wait cycles and mem_rdata=16'h1234 -> mem_req=1 and mem_we=0 for 3 cycles, then mbr_data=16'h1234 and busy=0.
REQ-040 With mbr_data=16'h00FF, set bit 9 and ack on the first wait cycle -> mem_we=1, mem_wdata=16'h00FF for 1 cycle, and mbr_data is unchanged.
REQ-041 With TIMEOUT=4, set bit 5 and never ack -> mem_req high for exactly 4 cycles, then timeout_err=1 and mbr_data is unchanged; err_clr then drives the flag to 0.
REQ-042 Set bits 10, 5 and 9 together -> only the ACC load occurs; while busy on a read, bit 10 is ignored; an ack on the timeout cycle completes the read with no error.
REQ-043 Assert rst_n low during WR_WAIT -> mem_req=0, busy=0 and mbr_data=0 with no clock edge, and timeout_err=0.
